vga_scan_gen: RTL

Master VGA 640x480@60 timing generator for the pride-flag renderers. Drives the `pix_x`/`pix_y` coordinates that every flag module consumes. Registers each flag's combinational 6-bit `color` onto the output pins, with hsync, vsync and blanking aligned to it. Also owns the frame counter used for temporal dithering and the flag-select index that picks which flag module is muxed in.

---
 rtl/vga_timing_pkg.sv | 37 +++
 rtl/btn_sync_edge.sv | 31 +++
 rtl/vga_scan_gen.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing constants, sync-window helpers and the RRGGBB pixel type.
package vga_timing_pkg;

    // 6-bit colour as driven to the resistor DAC: {R1,R0,G1,G0,B1,B0}.
    typedef logic [5:0] color_t;

    // First counter value inside a sync pulse (after active area and front porch).
    function automatic int sync_start(input int active, input int fp);
        return active + fp;
    endfunction

    // Last counter value inside a sync pulse.
    function automatic int sync_end(input int active, input int fp, input int sync);
        return active + fp + sync - 1;
    endfunction

    // Horizontal timing, in pixel clocks.
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    // Vertical timing, in lines.
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    // Sync pulse positions for the standard mode.
    localparam int VGA_HS_START = sync_start(VGA_H_ACTIVE, VGA_H_FP);
    localparam int VGA_HS_END   = sync_end(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC);
    localparam int VGA_VS_START = sync_start(VGA_V_ACTIVE, VGA_V_FP);
    localparam int VGA_VS_END   = sync_end(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC);

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for a raw button plus a one-clock rising-edge pulse.
module btn_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_pulse
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    // Resynchronize the button and remember its previous settled level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make all three flops sample together,
            // forming a real shift chain instead of collapsing into one stage.
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // High for exactly the one cycle where the settled level has just gone 0 -> 1.
    assign o_pulse = r_sync2 & ~r_prev;

endmodule

// File: rtl/vga_scan_gen.sv
// VGA scan generator: pixel/line counters, sync and blanking decodes, registered
// pin stage, frame counter and frame-aligned flag selection.
module vga_scan_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE  = VGA_H_ACTIVE,
    parameter int H_FP      = VGA_H_FP,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BP      = VGA_H_BP,
    parameter int V_ACTIVE  = VGA_V_ACTIVE,
    parameter int V_FP      = VGA_V_FP,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BP      = VGA_V_BP,
    parameter int NUM_FLAGS = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sel_next,
    input  color_t                       color,
    output logic [9:0]                   pix_x,
    output logic [9:0]                   pix_y,
    output logic [7:0]                   frame_cnt,
    output logic [$clog2(NUM_FLAGS)-1:0] flag_idx,
    output color_t                       rgb,
    output logic                         hsync,
    output logic                         vsync,
    output logic                         de
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FW      = $clog2(NUM_FLAGS);

    localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]    H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0]    V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0]    HS_FIRST = 10'(sync_start(H_ACTIVE, H_FP));
    localparam logic [9:0]    HS_LAST  = 10'(sync_end(H_ACTIVE, H_FP, H_SYNC));
    localparam logic [9:0]    VS_FIRST = 10'(sync_start(V_ACTIVE, V_FP));
    localparam logic [9:0]    VS_LAST  = 10'(sync_end(V_ACTIVE, V_FP, V_SYNC));
    localparam logic [FW-1:0] IDX_LAST = FW'(NUM_FLAGS - 1);

    logic [9:0]    r_pix_x;
    logic [9:0]    r_pix_y;
    logic [7:0]    r_frame_cnt;
    logic [FW-1:0] r_flag_idx;
    logic          r_pending;
    color_t        r_rgb;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_de;

    logic          w_line_end;
    logic          w_last_line;
    logic          w_frame_end;
    logic          w_active;
    logic          w_hsync_n;
    logic          w_vsync_n;
    logic          w_sel_pulse;
    logic [FW-1:0] w_flag_idx_nxt;
    logic          w_pending_nxt;

    btn_sync_edge u_btn (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (sel_next),
        .o_pulse (w_sel_pulse)
    );

    assign w_line_end  = (r_pix_x == H_LAST);
    assign w_last_line = (r_pix_y == V_LAST);
    assign w_frame_end = w_line_end & w_last_line;
    assign w_active    = (r_pix_x < H_VIS) && (r_pix_y < V_VIS);
    assign w_hsync_n   = !((r_pix_x >= HS_FIRST) && (r_pix_x <= HS_LAST));
    assign w_vsync_n   = !((r_pix_y >= VS_FIRST) && (r_pix_y <= VS_LAST));

    // Raster scan: column every clock, row on column wrap, both wrap at their totals.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pix_x <= '0;
            r_pix_y <= '0;
        end else if (w_line_end) begin
            r_pix_x <= '0;
            r_pix_y <= w_last_line ? '0 : r_pix_y + 10'd1;
        end else begin
            r_pix_x <= r_pix_x + 10'd1;
        end
    end

    // Next flag index and pending request; the selection only moves at a frame boundary.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        w_flag_idx_nxt = r_flag_idx;
        w_pending_nxt  = r_pending;
        if (w_frame_end && r_pending) begin
            w_flag_idx_nxt = (r_flag_idx == IDX_LAST) ? '0 : r_flag_idx + FW'(1);
            // A press landing on the boundary itself is carried into the next frame.
            w_pending_nxt  = w_sel_pulse;
        end else if (w_sel_pulse) begin
            // Extra presses while a request is already pending fold into it.
            w_pending_nxt  = 1'b1;
        end
    end

    // Frame counter, pending request and selected flag, all updated together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt <= '0;
            r_flag_idx  <= '0;
            r_pending   <= 1'b0;
        end else begin
            if (w_frame_end) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
            r_flag_idx <= w_flag_idx_nxt;
            r_pending  <= w_pending_nxt;
        end
    end

    // Pin register: colour, syncs and blanking all come from the same coordinate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rgb   <= '0;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_de    <= 1'b0;
        end else begin
            r_rgb   <= w_active ? color : '0;
            r_hsync <= w_hsync_n;
            r_vsync <= w_vsync_n;
            r_de    <= w_active;
        end
    end

    assign pix_x     = r_pix_x;
    assign pix_y     = r_pix_y;
    assign frame_cnt = r_frame_cnt;
    assign flag_idx  = r_flag_idx;
    assign rgb       = r_rgb;
    assign hsync     = r_hsync;
    assign vsync     = r_vsync;
    assign de        = r_de;

endmodule
